// File: rtl/intcode_pkg.sv
// Shared constants for the intcode CPU bus and its memory-mapped I/O port.
// Addresses, status word layout and the data width live here.
package intcode_pkg;

  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] IN_ADDR   = 32'hFFFF_0000;
  localparam logic [DATA_W-1:0] OUT_ADDR  = 32'hFFFF_0001;
  localparam logic [DATA_W-1:0] STAT_ADDR = 32'hFFFF_0002;

  localparam int STAT_IN_NONEMPTY = 0;
  localparam int STAT_OUT_FULL    = 1;
  localparam int STAT_COUNT_LSB   = 16;

  function automatic logic [DATA_W-1:0] stat_word(
    input logic [15:0] in_cnt,
    input logic        out_full,
    input logic        in_nonempty
  );
    logic [DATA_W-1:0] w;
    w = '0;
    w[STAT_COUNT_LSB +: 16] = in_cnt;
    w[STAT_OUT_FULL]        = out_full;
    w[STAT_IN_NONEMPTY]     = in_nonempty;
    return w;
  endfunction

endpackage

// File: rtl/intcode_io_port_if.sv
// CPU address/strobe and host FIFO handshakes of the intcode I/O port.
// The shared data bus is a tristate net and stays a plain port.
interface intcode_io_port_if;
  import intcode_pkg::*;

  logic [DATA_W-1:0] address_bus;
  logic              ram_write;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              underflow;
  logic              overflow;

  modport master (
    output address_bus, ram_write,
    output in_data, in_valid, out_ready,
    input  in_ready, out_data, out_valid,
    input  underflow, overflow
  );

  modport slave (
    input  address_bus, ram_write,
    input  in_data, in_valid, out_ready,
    output in_ready, out_data, out_valid,
    output underflow, overflow
  );

endinterface

// File: rtl/intcode_fifo.sv
// Synchronous FIFO with full/empty/count; push while full is legal
// when a pop happens on the same cycle.
module intcode_fifo
  import intcode_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(do_push);
    rd_ptr_d = rd_ptr_q + AW'(do_pop);
    cnt_d    = cnt_q;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push)
      mem_q[wr_ptr_q] <= din_i;
  end

  assign dout_o  = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o = cnt_q;

endmodule

// File: rtl/intcode_io_port.sv
// Memory-mapped I/O responder: host-filled input FIFO read by the CPU,
// CPU-filled output FIFO drained by the host, plus a status word.
module intcode_io_port #(
  parameter int          DEPTH       = 16,
  parameter logic [31:0] IN_ADDR     = intcode_pkg::IN_ADDR,
  parameter logic [31:0] OUT_ADDR    = intcode_pkg::OUT_ADDR,
  parameter logic [31:0] STAT_ADDR   = intcode_pkg::STAT_ADDR,
  parameter logic [31:0] EMPTY_VALUE = 32'h0
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire  [31:0] data_bus,
  intcode_io_port_if.slave bus
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] in_head, stat_val, rd_val;
  logic [AW:0] in_cnt;
  logic        in_full, in_empty;
  logic        out_full, out_empty;
  logic        rd_match, st_match, wr_match;
  logic        rd_start, in_pop, in_push;
  logic        wr_edge, out_pop, out_push;
  logic        show_empty;

  logic rd_active_q, rd_active_d;
  logic win_empty_q, win_empty_d;
  logic wr_q, wr_d;
  logic underflow_q, underflow_d;
  logic overflow_q, overflow_d;

  assign rd_match = (bus.address_bus == IN_ADDR) && !bus.ram_write;
  assign st_match = (bus.address_bus == STAT_ADDR) && !bus.ram_write;
  assign wr_match = bus.ram_write && (bus.address_bus == OUT_ADDR);

  // Pop only when the CPU leaves the window, so the value stays stable
  assign rd_start = rd_match && !rd_active_q;
  assign in_pop   = rd_active_q && !rd_match && !win_empty_q;
  assign in_push  = bus.in_valid && bus.in_ready;

  assign wr_edge  = wr_match && !wr_q;
  assign out_pop  = bus.out_valid && bus.out_ready;
  assign out_push = wr_edge && (!out_full || out_pop);

  always_comb begin
    rd_active_d = rd_match;
    win_empty_d = rd_start ? in_empty : win_empty_q;
    wr_d        = wr_match;
    underflow_d = underflow_q | (rd_start && in_empty);
    overflow_d  = overflow_q | (wr_edge && out_full && !out_pop);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_active_q <= 1'b0;
      win_empty_q <= 1'b0;
      wr_q        <= 1'b0;
      underflow_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      rd_active_q <= rd_active_d;
      win_empty_q <= win_empty_d;
      wr_q        <= wr_d;
      underflow_q <= underflow_d;
      overflow_q  <= overflow_d;
    end
  end

  intcode_fifo #(.DEPTH(DEPTH)) u_in_fifo (
    .clk     (clock),
    .rst     (reset),
    .push_i  (in_push),
    .pop_i   (in_pop),
    .din_i   (bus.in_data),
    .dout_o  (in_head),
    .full_o  (in_full),
    .empty_o (in_empty),
    .count_o (in_cnt)
  );

  intcode_fifo #(.DEPTH(DEPTH)) u_out_fifo (
    .clk     (clock),
    .rst     (reset),
    .push_i  (out_push),
    .pop_i   (out_pop),
    .din_i   (data_bus),
    .dout_o  (bus.out_data),
    .full_o  (out_full),
    .empty_o (out_empty),
    .count_o ()
  );

  // Mid-window pushes must not change what the CPU is already seeing
  assign show_empty = rd_active_q ? win_empty_q : in_empty;
  assign rd_val     = show_empty ? EMPTY_VALUE : in_head;
  assign stat_val   = intcode_pkg::stat_word(16'(in_cnt), out_full,
                                             !in_empty);

  assign data_bus = rd_match ? rd_val
                  : st_match ? stat_val
                  : 'z;

  assign bus.in_ready  = !in_full;
  assign bus.out_valid = !out_empty;
  assign bus.underflow = underflow_q;
  assign bus.overflow  = overflow_q;

endmodule

// File: tb/tb_intcode_io_port.sv
// Self-checking bench for intcode_io_port: decode table, scoreboarded
// FIFO traffic and hand-written multi-cycle corner cases.
module tb_intcode_io_port;
  import intcode_pkg::*;

  localparam int          DEPTH   = 16;
  localparam logic [31:0] EMPTY_V = 32'hDEAD_BEEF;
  localparam logic [31:0] IDLE_A  = 32'h0000_1000;

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic        chk_bus;
    logic [31:0] exp_bus;
    logic        exp_ov;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_oe = 1'b0;
  logic [31:0] cpu_dout = '0;
  wire  [31:0] data_bus;

  assign data_bus = cpu_oe ? cpu_dout : 'z;

  intcode_io_port_if io();

  intcode_io_port #(
    .DEPTH       (DEPTH),
    .EMPTY_VALUE (EMPTY_V)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .data_bus (data_bus),
    .bus      (io.slave)
  );

  always #5 clock = ~clock;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] in_sb[$];
  logic [31:0] out_sb[$];
  logic        ov_model = 1'b0;
  vec_t        tbl[13];

  function automatic logic [31:0] stat(input int cnt,
                                       input logic ofull,
                                       input logic ine);
    return {cnt[15:0], 14'd0, ofull, ine};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic host_push(input logic [31:0] v);
    io.in_data  = v;
    io.in_valid = 1'b1;
    settle();
    chk("push_ready", {31'd0, io.in_ready}, 32'd1);
    step();
    in_sb.push_back(v);
    io.in_valid = 1'b0;
  endtask

  task automatic stat_chk(input string nm, input logic [31:0] exp);
    io.address_bus = STAT_ADDR;
    io.ram_write   = 1'b0;
    settle();
    chk(nm, data_bus, exp);
    io.address_bus = IDLE_A;
  endtask

  task automatic cpu_window(input int cycles);
    logic [31:0] exp;
    exp = (in_sb.size() > 0) ? in_sb[0] : EMPTY_V;
    io.address_bus = IN_ADDR;
    io.ram_write   = 1'b0;
    for (int i = 0; i < cycles; i++) begin
      settle();
      chk("rd_data", data_bus, exp);
      step();
    end
    io.address_bus = IDLE_A;
    step();
    if (in_sb.size() > 0) void'(in_sb.pop_front());
  endtask

  task automatic cpu_write(input logic [31:0] v, input logic pop);
    logic acc;
    io.address_bus = OUT_ADDR;
    io.ram_write   = 1'b1;
    cpu_oe         = 1'b1;
    cpu_dout       = v;
    io.out_ready   = pop;
    settle();
    if (pop && out_sb.size() > 0)
      chk("pop_data", io.out_data, out_sb[0]);
    acc = (out_sb.size() < DEPTH) || (pop && out_sb.size() > 0);
    step();
    if (pop && out_sb.size() > 0) void'(out_sb.pop_front());
    if (acc) out_sb.push_back(v);
    else     ov_model = 1'b1;
    io.ram_write   = 1'b0;
    cpu_oe         = 1'b0;
    io.out_ready   = 1'b0;
    io.address_bus = IDLE_A;
    step();
  endtask

  task automatic drain_out(input int exp_n);
    int n;
    n = 0;
    io.out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 4; i++) begin
      settle();
      if (io.out_valid) begin
        if (out_sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL drain_extra: got %h want none", io.out_data);
        end else begin
          chk("out_data", io.out_data, out_sb.pop_front());
        end
        n++;
      end
      step();
    end
    io.out_ready = 1'b0;
    chk("drain_n", n, exp_n);
  endtask

  initial begin
    logic        acc;
    logic [31:0] next_v;

    io.address_bus = IDLE_A;
    io.ram_write   = 1'b0;
    io.in_data     = '0;
    io.in_valid    = 1'b0;
    io.out_ready   = 1'b0;

    // reset values
    #1;
    chk("rst_in_ready",  {31'd0, io.in_ready},  32'd1);
    chk("rst_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("rst_out_data",  io.out_data,           32'd0);
    chk("rst_underflow", {31'd0, io.underflow}, 32'd0);
    chk("rst_overflow",  {31'd0, io.overflow},  32'd0);
    step();
    step();
    reset = 1'b0;
    step();

    // decode table, input FIFO preloaded with 11, 22
    tbl[0]  = '{STAT_ADDR, 1'b0, 32'd0, 1'b1, 32'h0002_0001, 1'b0};
    tbl[1]  = '{IN_ADDR,   1'b0, 32'd0, 1'b1, 32'd11,        1'b0};
    tbl[2]  = '{IDLE_A,    1'b0, 32'd0, 1'b0, 32'd0,         1'b0};
    tbl[3]  = '{STAT_ADDR, 1'b0, 32'd0, 1'b1, 32'h0001_0001, 1'b0};
    tbl[4]  = '{IN_ADDR,   1'b1, 32'd5, 1'b0, 32'd0,         1'b0};
    tbl[5]  = '{STAT_ADDR, 1'b0, 32'd0, 1'b1, 32'h0001_0001, 1'b0};
    tbl[6]  = '{OUT_ADDR,  1'b0, 32'd0, 1'b0, 32'd0,         1'b0};
    tbl[7]  = '{OUT_ADDR,  1'b1, 32'd33, 1'b0, 32'd0,        1'b0};
    tbl[8]  = '{IDLE_A,    1'b0, 32'd0, 1'b0, 32'd0,         1'b1};
    tbl[9]  = '{STAT_ADDR, 1'b1, 32'd1, 1'b0, 32'd0,         1'b1};
    tbl[10] = '{IN_ADDR,   1'b0, 32'd0, 1'b1, 32'd22,        1'b1};
    tbl[11] = '{IDLE_A,    1'b0, 32'd0, 1'b0, 32'd0,         1'b1};
    tbl[12] = '{STAT_ADDR, 1'b0, 32'd0, 1'b1, 32'h0000_0000, 1'b1};
    host_push(32'd11);
    host_push(32'd22);
    for (int i = 0; i < 13; i++) begin
      io.address_bus = tbl[i].addr;
      io.ram_write   = tbl[i].wr;
      cpu_oe         = tbl[i].wr;
      cpu_dout       = tbl[i].wdata;
      settle();
      if (tbl[i].chk_bus)
        chk($sformatf("tbl%0d_bus", i), data_bus, tbl[i].exp_bus);
      chk($sformatf("tbl%0d_ov", i), {31'd0, io.out_valid},
          {31'd0, tbl[i].exp_ov});
      if (tbl[i].wr && tbl[i].addr == OUT_ADDR)
        out_sb.push_back(tbl[i].wdata);
      step();
    end
    io.address_bus = IDLE_A;
    io.ram_write   = 1'b0;
    cpu_oe         = 1'b0;
    in_sb.delete();
    step();
    drain_out(1);

    // held read window, then a second window
    host_push(32'd5);
    host_push(32'd7);
    stat_chk("cnt2", stat(2, 1'b0, 1'b1));
    cpu_window(4);
    stat_chk("cnt1", stat(1, 1'b0, 1'b1));
    cpu_window(1);
    stat_chk("cnt0", stat(0, 1'b0, 1'b0));
    chk("no_underflow", {31'd0, io.underflow}, 32'd0);
    step();

    // empty read with a push landing mid-window
    io.address_bus = IN_ADDR;
    settle();
    chk("uf_bus0", data_bus, EMPTY_V);
    step();
    io.in_data  = 32'd9;
    io.in_valid = 1'b1;
    settle();
    chk("uf_ready", {31'd0, io.in_ready}, 32'd1);
    chk("uf_bus1", data_bus, EMPTY_V);
    step();
    in_sb.push_back(32'd9);
    io.in_valid = 1'b0;
    settle();
    chk("uf_bus2", data_bus, EMPTY_V);
    step();
    io.address_bus = IDLE_A;
    step();
    chk("underflow", {31'd0, io.underflow}, 32'd1);
    stat_chk("uf_keep9", stat(1, 1'b0, 1'b1));
    cpu_window(1);
    stat_chk("uf_after", stat(0, 1'b0, 1'b0));
    step();

    // held write strobe pushes once
    io.address_bus = OUT_ADDR;
    io.ram_write   = 1'b1;
    cpu_oe         = 1'b1;
    cpu_dout       = 32'd42;
    settle();
    chk("w42_valid0", {31'd0, io.out_valid}, 32'd0);
    step();
    out_sb.push_back(32'd42);
    chk("w42_valid1", {31'd0, io.out_valid}, 32'd1);
    chk("w42_data", io.out_data, 32'd42);
    step();
    step();
    io.ram_write   = 1'b0;
    cpu_oe         = 1'b0;
    io.address_bus = IDLE_A;
    step();
    drain_out(1);

    // output FIFO full: accept with pop, drop without
    for (int i = 0; i < DEPTH; i++)
      cpu_write(32'd100 + 32'(i), 1'b0);
    stat_chk("out_full", stat(0, 1'b1, 1'b0));
    cpu_write(32'd77, 1'b1);
    chk("ov_on_pop", {31'd0, io.overflow}, {31'd0, ov_model});
    stat_chk("still_full", stat(0, 1'b1, 1'b0));
    cpu_write(32'd77, 1'b0);
    chk("ov_drop", {31'd0, io.overflow}, {31'd0, ov_model});
    drain_out(DEPTH);

    // input FIFO full, push while popping, pointer wrap
    for (int i = 1; i <= DEPTH; i++)
      host_push(32'(i));
    settle();
    chk("in_full_rdy", {31'd0, io.in_ready}, 32'd0);
    stat_chk("in_full", stat(DEPTH, 1'b0, 1'b1));
    next_v = 32'(DEPTH + 1);
    for (int it = 0; it < 4; it++) begin
      io.address_bus = IN_ADDR;
      io.in_valid    = 1'b0;
      settle();
      chk("wrap_rd", data_bus, in_sb[0]);
      step();
      io.address_bus = IDLE_A;
      io.in_valid    = 1'b1;
      io.in_data     = next_v;
      settle();
      acc = in_sb.size() < DEPTH;
      chk("wrap_ready", {31'd0, io.in_ready}, {31'd0, acc});
      step();
      void'(in_sb.pop_front());
      if (acc) begin
        in_sb.push_back(next_v);
        next_v++;
      end
    end
    io.in_valid = 1'b0;
    stat_chk("wrap_cnt", stat(in_sb.size(), 1'b0, 1'b1));
    step();
    while (in_sb.size() > 0)
      cpu_window(1);
    stat_chk("wrap_empty", stat(0, 1'b0, 1'b0));
    step();

    // status word, then reset inside a read window
    host_push(32'd61);
    host_push(32'd62);
    host_push(32'd63);
    for (int i = 0; i < DEPTH; i++)
      cpu_write(32'd200 + 32'(i), 1'b0);
    stat_chk("stat_word", stat(3, 1'b1, 1'b1));
    io.address_bus = IN_ADDR;
    settle();
    chk("pre_rst_rd", data_bus, 32'd61);
    step();
    reset = 1'b1;
    settle();
    chk("mr_in_ready",  {31'd0, io.in_ready},  32'd1);
    chk("mr_out_valid", {31'd0, io.out_valid}, 32'd0);
    chk("mr_out_data",  io.out_data,           32'd0);
    chk("mr_underflow", {31'd0, io.underflow}, 32'd0);
    chk("mr_overflow",  {31'd0, io.overflow},  32'd0);
    chk("mr_bus", data_bus, EMPTY_V);
    step();
    io.address_bus = IDLE_A;
    step();
    reset = 1'b0;
    in_sb.delete();
    out_sb.delete();
    ov_model = 1'b0;
    step();
    stat_chk("post_rst", stat(0, 1'b0, 1'b0));
    chk("post_rst_uf", {31'd0, io.underflow}, 32'd0);
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
